axi_mem_slave: RTL

- AXI4 responder (target end) that terminates the master-side interface of a DUT such as the AXI pass-through.
- Backed by a DEPTH x DW word memory.
- Accepts one write burst (AW+W, returns B) and one read burst (AR, returns R) at a time. The read and write paths run independently and concurrently.
- Used as the downstream memory model in the axi2axi bench.

---
 rtl/axi_mem_slave.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_slave.sv
// Purpose: AXI4 memory responder on a DEPTH x DW word array; one write burst and one read burst in flight at a time.
// Latency: B valid the cycle after the last W beat; first R beat the cycle after AR, then one beat per cycle.
// Backpressure: readies are decoded from FSM state; B and R fields are held stable until b_ready / r_ready.
module axi_mem_slave #(
  parameter int          DW    = 64,
  parameter int          AW    = 32,
  parameter int          IDW   = 1,
  parameter int          DEPTH = 1024,
  parameter int unsigned BASE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDW-1:0]    axi_s_aw_id_i,
  input  logic [AW-1:0]     axi_s_aw_addr_i,
  input  logic [7:0]        axi_s_aw_len_i,
  input  logic [2:0]        axi_s_aw_size_i,
  input  logic [1:0]        axi_s_aw_burst_i,
  input  logic              axi_s_aw_valid_i,
  output logic              axi_s_aw_ready_o,
  input  logic [DW-1:0]     axi_s_w_data_i,
  input  logic [DW/8-1:0]   axi_s_w_strb_i,
  input  logic              axi_s_w_last_i,
  input  logic              axi_s_w_valid_i,
  output logic              axi_s_w_ready_o,
  output logic [IDW-1:0]    axi_s_b_id_o,
  output logic [1:0]        axi_s_b_resp_o,
  output logic              axi_s_b_valid_o,
  input  logic              axi_s_b_ready_i,
  input  logic [IDW-1:0]    axi_s_ar_id_i,
  input  logic [AW-1:0]     axi_s_ar_addr_i,
  input  logic [7:0]        axi_s_ar_len_i,
  input  logic [2:0]        axi_s_ar_size_i,
  input  logic [1:0]        axi_s_ar_burst_i,
  input  logic              axi_s_ar_valid_i,
  output logic              axi_s_ar_ready_o,
  output logic [IDW-1:0]    axi_s_r_id_o,
  output logic [DW-1:0]     axi_s_r_data_o,
  output logic [1:0]        axi_s_r_resp_o,
  output logic              axi_s_r_last_o,
  output logic              axi_s_r_valid_o,
  input  logic              axi_s_r_ready_i,
  output logic              wlast_err_o
);

  localparam int BPW = DW / 8;
  localparam int BSH = $clog2(BPW);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Word index of an address inside the window (only meaningful for in-range bursts).
  function automatic logic [IW-1:0] word_index(input logic [AW-1:0] addr);
    logic [AW-1:0] off;
    off = addr - BASE_A;
    return IW'(off >> BSH);
  endfunction

  // Below-base start, run past the top word, narrow size or reserved burst type.
  function automatic logic burst_err(input logic [AW-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [AW:0] off;
    logic [AW:0] last_idx;
    off      = {1'b0, addr} - {1'b0, BASE_A};
    last_idx = {1'b0, off[AW-1:0] >> BSH} + (AW+1)'(len);
    return off[AW] || (last_idx >= (AW+1)'(DEPTH)) || (size != 3'(BSH)) || (burst == 2'b11);
  endfunction

  logic [DW-1:0] mem [DEPTH];

  w_state_t       w_state, w_state_nxt;
  logic [IDW-1:0] w_id_q;
  logic [IW-1:0]  w_idx_q;
  logic [7:0]     w_len_q, w_cnt_q;
  logic [1:0]     w_burst_q;
  logic           w_err_q;
  logic           aw_hs, w_hs, w_final;

  r_state_t       r_state, r_state_nxt;
  logic [IDW-1:0] r_id_q;
  logic [IW-1:0]  r_idx_q, r_idx_nxt, ar_idx;
  logic [7:0]     r_len_q, r_cnt_q;
  logic [1:0]     r_burst_q;
  logic           r_err_q, ar_err;
  logic [DW-1:0]  r_data_q;
  logic           ar_hs, r_hs;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  // Write FSM next state and decoded AW/W/B outputs.
  always_comb begin
    w_state_nxt      = w_state;
    axi_s_aw_ready_o = 1'b0;
    axi_s_w_ready_o  = 1'b0;
    axi_s_b_valid_o  = 1'b0;
    axi_s_b_resp_o   = 2'b00;
    axi_s_b_id_o     = w_id_q;
    aw_hs            = 1'b0;
    w_hs             = 1'b0;
    w_final          = (w_cnt_q == w_len_q);
    unique case (w_state)
      W_IDLE: begin
        axi_s_aw_ready_o = !rst;
        aw_hs            = axi_s_aw_valid_i && !rst;
        if (aw_hs) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi_s_w_ready_o = !rst;
        w_hs            = axi_s_w_valid_i && !rst;
        if (w_hs && w_final) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi_s_b_valid_o = 1'b1;
        axi_s_b_resp_o  = w_err_q ? 2'b10 : 2'b00;
        if (axi_s_b_ready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: latch AW, step index/counter per beat, flag WLAST mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_id_q      <= '0;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_burst_q   <= '0;
      w_err_q     <= 1'b0;
      wlast_err_o <= 1'b0;
    end else begin
      wlast_err_o <= w_hs && (axi_s_w_last_i != w_final);
      if (aw_hs) begin
        w_id_q    <= axi_s_aw_id_i;
        w_idx_q   <= word_index(axi_s_aw_addr_i);
        w_len_q   <= axi_s_aw_len_i;
        w_cnt_q   <= 8'd0;
        w_burst_q <= axi_s_aw_burst_i;
        w_err_q   <= burst_err(axi_s_aw_addr_i, axi_s_aw_len_i, axi_s_aw_size_i, axi_s_aw_burst_i);
      end else if (w_hs) begin
        w_cnt_q <= w_cnt_q + 8'd1;
        if (w_burst_q != 2'b00) w_idx_q <= w_idx_q + IW'(1);
      end
    end
  end

  // Byte-enabled memory write; error bursts leave memory untouched.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err_q) begin
      for (int b = 0; b < BPW; b++) begin
        if (axi_s_w_strb_i[b]) mem[w_idx_q][8*b +: 8] <= axi_s_w_data_i[8*b +: 8];
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Read FSM next state and decoded AR/R outputs.
  always_comb begin
    r_state_nxt      = r_state;
    axi_s_ar_ready_o = 1'b0;
    axi_s_r_valid_o  = 1'b0;
    axi_s_r_last_o   = 1'b0;
    axi_s_r_resp_o   = 2'b00;
    axi_s_r_id_o     = r_id_q;
    axi_s_r_data_o   = r_data_q;
    ar_hs            = 1'b0;
    r_hs             = 1'b0;
    ar_idx           = word_index(axi_s_ar_addr_i);
    ar_err           = burst_err(axi_s_ar_addr_i, axi_s_ar_len_i, axi_s_ar_size_i, axi_s_ar_burst_i);
    r_idx_nxt        = (r_burst_q == 2'b00) ? r_idx_q : r_idx_q + IW'(1);
    unique case (r_state)
      R_IDLE: begin
        axi_s_ar_ready_o = !rst;
        ar_hs            = axi_s_ar_valid_i && !rst;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        axi_s_r_valid_o = 1'b1;
        axi_s_r_last_o  = (r_cnt_q == r_len_q);
        axi_s_r_resp_o  = r_err_q ? 2'b10 : 2'b00;
        r_hs            = axi_s_r_ready_i;
        if (r_hs && axi_s_r_last_o) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read burst bookkeeping: the beat register loads on AR and on every non-final R handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else if (ar_hs) begin
      r_id_q    <= axi_s_ar_id_i;
      r_idx_q   <= ar_idx;
      r_len_q   <= axi_s_ar_len_i;
      r_cnt_q   <= 8'd0;
      r_burst_q <= axi_s_ar_burst_i;
      r_err_q   <= ar_err;
      r_data_q  <= ar_err ? '0 : mem[ar_idx];
    end else if (r_hs && (r_cnt_q != r_len_q)) begin
      r_cnt_q  <= r_cnt_q + 8'd1;
      r_idx_q  <= r_idx_nxt;
      r_data_q <= r_err_q ? '0 : mem[r_idx_nxt];
    end
  end

endmodule
